// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and byte-merge helper for reg_file.
// Macro: REGFILE_BYPASS_EN (used by reg_file) enables write-to-read bypass.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;

    localparam int REG_ZERO  = 0;
    localparam int REG_SP    = 29;
    localparam int REG_RA    = 31;

    // One byte lane: take the new byte when its lane enable is set.
    function automatic logic [7:0] merge(
        input logic [7:0] old_v,
        input logic [7:0] new_v,
        input logic       mask
    );
        return mask ? new_v : old_v;
    endfunction

endpackage

// File: rtl/reg_file_entry.sv
// reg_file_entry: one WIDTH-bit storage word with byte-lane write enables.
// Ports: clk, clr (async, active-high), we_i, wbe_i, wdata_i -> data_o.
module reg_file_entry
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               we_i,
    input  logic [WIDTH/8-1:0] wbe_i,
    input  logic [WIDTH-1:0]   wdata_i,
    output logic [WIDTH-1:0]   data_o
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        for (int i = 0; i < NB; i++) begin
            data_d[8*i +: 8] = merge(data_q[8*i +: 8],
                                     wdata_i[8*i +: 8],
                                     wbe_i[i]);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_q <= '0;
        end else if (we_i) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: 1W/2R register file with byte-lane write, optional zero reg
// and optional registered read. Ports: clk, clr, we, wbe, waddr, wdata,
// raddr1/2 -> rdata1/2. Macro REGFILE_BYPASS_EN adds same-cycle bypass.
module reg_file
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int ZERO_REG = 1,
    parameter  int READ_REG = 0,
    localparam int AW       = $clog2(DEPTH),
    localparam int NB       = WIDTH / 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [NB-1:0]    wbe,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem [DEPTH];

    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic in_rng;
        logic is_zero;
        in_rng  = int'(a) < DEPTH;
        is_zero = (ZERO_REG != 0) && (int'(a) == REG_ZERO);
        return in_rng && !is_zero;
    endfunction

    function automatic logic [WIDTH-1:0] lanes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    m
    );
        logic [WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = merge(old_w[8*i +: 8], new_w[8*i +: 8], m[i]);
        end
        return r;
    endfunction

    // Address 0 has no storage when hardwired to zero.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        if ((ZERO_REG != 0) && (g == REG_ZERO)) begin : g_zero
            assign mem[g] = '0;
        end else begin : g_ent
            reg_file_entry #(
                .WIDTH   (WIDTH)
            ) u_entry (
                .clk     (clk),
                .clr     (clr),
                .we_i    (we && (waddr == AW'(g))),
                .wbe_i   (wbe),
                .wdata_i (wdata),
                .data_o  (mem[g])
            );
        end
    end

    logic [WIDTH-1:0] rd1_d;
    logic [WIDTH-1:0] rd2_d;

`ifdef REGFILE_BYPASS_EN
    logic wr_ok;
    assign wr_ok = we && !clr && addr_ok(waddr);
`endif

    always_comb begin
        rd1_d = '0;
        if (addr_ok(raddr1)) begin
            rd1_d = mem[raddr1];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (waddr == raddr1)) begin
            rd1_d = lanes(rd1_d, wdata, wbe);
        end
`endif
    end

    always_comb begin
        rd2_d = '0;
        if (addr_ok(raddr2)) begin
            rd2_d = mem[raddr2];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (waddr == raddr2)) begin
            rd2_d = lanes(rd2_d, wdata, wbe);
        end
`endif
    end

    if (READ_REG != 0) begin : g_rreg
        logic [WIDTH-1:0] rd1_q;
        logic [WIDTH-1:0] rd2_q;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                rd1_q <= '0;
                rd2_q <= '0;
            end else begin
                rd1_q <= rd1_d;
                rd2_q <= rd2_d;
            end
        end

        assign rdata1 = rd1_q;
        assign rdata2 = rd2_q;
    end else begin : g_rcomb
        assign rdata1 = rd1_d;
        assign rdata2 = rd2_d;
    end

endmodule
